// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter
// Single-port VRAM arbiter for the PPU. A read-only renderer port and a
// read/write CPU port each own a 1-deep request slot. Accesses take two
// cycles (ADDR, DATA), with nametable and palette mirroring applied at
// grant time. Read data is returned together with a one-cycle ack pulse.
module ppu_vram_arbiter #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_render_active,
   input  logic              i_mirror_v,
   input  logic              i_ren_req,
   input  logic [15:0]       i_ren_addr,
   output logic              o_ren_ack,
   output logic [DATA_W-1:0] o_ren_rdata,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [15:0]       i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_we,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_ovf_err
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   // Request slots
   logic              r_ren_pend;
   logic [13:0]       r_ren_addr;
   logic              r_cpu_pend;
   logic              r_cpu_we;
   logic [13:0]       r_cpu_addr;
   logic [DATA_W-1:0] r_cpu_wdata;

   // Owner of the access in flight
   logic              r_own_cpu;
   logic              r_own_we;

   logic              r_ren_ack;
   logic              r_cpu_ack;
   logic [DATA_W-1:0] r_ren_rdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_ovf_err;

   logic              w_ren_want;
   logic              w_cpu_want;
   logic              w_gnt_ren;
   logic              w_gnt_cpu;
   logic              w_gnt;
   logic [13:0]       w_g_addr;
   logic              w_g_we;
   logic [DATA_W-1:0] w_g_wdata;
   logic              w_g_chr;
   logic              w_bank;
   logic [13:0]       w_map_addr;
   logic              w_unused_addr_hi;

   // A request pulse is eligible for grant in the cycle it arrives; an
   // occupied slot is always served before the pulse that arrives with it.
   assign w_ren_want = r_ren_pend | i_ren_req;
   assign w_cpu_want = r_cpu_pend | i_cpu_req;
   assign w_gnt      = w_gnt_ren | w_gnt_cpu;

   assign w_unused_addr_hi = ^{i_ren_addr[15:14], i_cpu_addr[15:14]};

   // State register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next state and grant decision (only in IDLE and DATA)
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_ren   = 1'b0;
      w_gnt_cpu   = 1'b0;
      case (r_state)
         S_IDLE, S_DATA: begin
            if (i_render_active) begin
               w_gnt_ren = w_ren_want;
               w_gnt_cpu = w_cpu_want & ~w_ren_want;
            end else begin
               w_gnt_cpu = w_cpu_want;
               w_gnt_ren = w_ren_want & ~w_cpu_want;
            end
            w_state_nxt = (w_gnt_ren | w_gnt_cpu) ? S_ADDR : S_IDLE;
         end
         S_ADDR:  w_state_nxt = S_DATA;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Granted request fields and the mirrored physical address
   always_comb begin
      w_g_addr  = '0;
      w_g_we    = 1'b0;
      w_g_wdata = '0;
      if (w_gnt_cpu) begin
         w_g_addr  = r_cpu_pend ? r_cpu_addr  : i_cpu_addr[13:0];
         w_g_we    = r_cpu_pend ? r_cpu_we    : i_cpu_we;
         w_g_wdata = r_cpu_pend ? r_cpu_wdata : i_cpu_wdata;
      end else if (w_gnt_ren) begin
         w_g_addr  = r_ren_pend ? r_ren_addr  : i_ren_addr[13:0];
      end
      w_g_chr    = ~w_g_addr[13];
      w_bank     = i_mirror_v ? w_g_addr[10] : w_g_addr[11];
      w_map_addr = w_g_addr;
      if (w_g_addr[13] && (w_g_addr[13:8] != 6'h3F)) begin
         w_map_addr = {3'b100, w_bank, w_g_addr[9:0]};
      end else if (w_g_addr[13]) begin
         w_map_addr = {6'h3F, 3'b000,
                       (w_g_addr[1:0] == 2'b00) ? 1'b0 : w_g_addr[4],
                       w_g_addr[3:0]};
      end
   end

   // Slots, memory-side drive, data return and overflow flag
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_ren_pend  <= 1'b0;
         r_ren_addr  <= '0;
         r_cpu_pend  <= 1'b0;
         r_cpu_we    <= 1'b0;
         r_cpu_addr  <= '0;
         r_cpu_wdata <= '0;
         r_own_cpu   <= 1'b0;
         r_own_we    <= 1'b0;
         r_ren_ack   <= 1'b0;
         r_cpu_ack   <= 1'b0;
         r_ren_rdata <= '0;
         r_cpu_rdata <= '0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_ovf_err   <= 1'b0;
      end else begin
         r_ren_ack <= 1'b0;
         r_cpu_ack <= 1'b0;

         // Granted slot reloads only if a fresh pulse arrives behind it
         if (w_gnt_ren) begin
            r_ren_pend <= r_ren_pend & i_ren_req;
            if (r_ren_pend && i_ren_req) r_ren_addr <= i_ren_addr[13:0];
         end else if (i_ren_req) begin
            if (r_ren_pend) begin
               r_ovf_err <= 1'b1;
            end else begin
               r_ren_pend <= 1'b1;
               r_ren_addr <= i_ren_addr[13:0];
            end
         end

         if (w_gnt_cpu) begin
            r_cpu_pend <= r_cpu_pend & i_cpu_req;
            if (r_cpu_pend && i_cpu_req) begin
               r_cpu_addr  <= i_cpu_addr[13:0];
               r_cpu_we    <= i_cpu_we;
               r_cpu_wdata <= i_cpu_wdata;
            end
         end else if (i_cpu_req) begin
            if (r_cpu_pend) begin
               r_ovf_err <= 1'b1;
            end else begin
               r_cpu_pend  <= 1'b1;
               r_cpu_addr  <= i_cpu_addr[13:0];
               r_cpu_we    <= i_cpu_we;
               r_cpu_wdata <= i_cpu_wdata;
            end
         end

         // CHR is ROM: the write completes but never strobes memory
         if (w_gnt) begin
            r_mem_addr  <= ADDR_W'(w_map_addr);
            r_mem_we    <= w_g_we & ~w_g_chr;
            r_mem_wdata <= w_g_wdata;
            r_own_cpu   <= w_gnt_cpu;
            r_own_we    <= w_g_we;
         end else begin
            r_mem_we    <= 1'b0;
         end

         if (r_state == S_DATA) begin
            if (r_own_cpu) begin
               r_cpu_ack <= 1'b1;
               if (!r_own_we) r_cpu_rdata <= i_mem_rdata;
            end else begin
               r_ren_ack   <= 1'b1;
               r_ren_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_ren_ack   = r_ren_ack;
   assign o_ren_rdata = r_ren_rdata;
   assign o_cpu_ack   = r_cpu_ack;
   assign o_cpu_rdata = r_cpu_rdata;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_we    = r_mem_we;
   assign o_mem_wdata = r_mem_wdata;
   assign o_ovf_err   = r_ovf_err;

endmodule
